// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and source encodings for the common data bus arbiter.
package cdb_arbiter_pkg;

  localparam int DEF_ROB_ID_W    = 4;
  localparam int DEF_QUEUE_DEPTH = 4;
  localparam int DATA_W          = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  // Round-robin choice: the source that did not win the previous conflict.
  function automatic cdb_src_e rr_other(input cdb_src_e last);
    rr_other = (last == SRC_LSB) ? SRC_ALU : SRC_LSB;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the CDB, grouped for the arbiter port.
interface cdb_arbiter_if #(
  parameter int ROB_ID_W = cdb_arbiter_pkg::DEF_ROB_ID_W
);

  logic                rdy_in;
  logic                clear_all;
  logic                alu_valid;
  logic [ROB_ID_W-1:0] alu_rob_id;
  logic [31:0]         alu_value;
  logic                alu_full;
  logic                lsb_valid;
  logic [ROB_ID_W-1:0] lsb_rob_id;
  logic [31:0]         lsb_value;
  logic                lsb_full;
  logic                cdb_valid;
  logic [ROB_ID_W-1:0] cdb_rob_id;
  logic [31:0]         cdb_value;
  logic                cdb_src;

  modport master (
    output rdy_in, clear_all,
    output alu_valid, alu_rob_id, alu_value,
    output lsb_valid, lsb_rob_id, lsb_value,
    input  alu_full, lsb_full,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );

  modport slave (
    input  rdy_in, clear_all,
    input  alu_valid, alu_rob_id, alu_value,
    input  lsb_valid, lsb_rob_id, lsb_value,
    output alu_full, lsb_full,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );

endinterface

// File: rtl/cdb_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so the pointers wrap naturally.
module cdb_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign head_data = mem_r[head_r];

  // A push into a full queue is dropped; a flush overrides push and pop.
  always_comb begin
    do_push_s = push && !full && !flush;
    do_pop_s  = pop && !empty && !flush;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (do_push_s) tail_r <= tail_r + PTR_W'(1);
      if (do_pop_s)  head_r <= head_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are meaningless while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[tail_r] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB owner: queues ALU and LSB results and broadcasts one per cycle.
// Define CDB_PRIO_LSB_EN for fixed LSB priority instead of round-robin.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ROB_ID_W    = DEF_ROB_ID_W,
  parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH
) (
  input  logic          clk_in,
  input  logic          rst_in,
  cdb_arbiter_if.slave  bus
);

  localparam int ENTRY_W = ROB_ID_W + DATA_W;

  logic               act_s;
  logic               flush_s;
  logic               alu_empty_s;
  logic               lsb_empty_s;
  logic               alu_full_s;
  logic               lsb_full_s;
  logic [ENTRY_W-1:0] alu_head_s;
  logic [ENTRY_W-1:0] lsb_head_s;
  logic [ENTRY_W-1:0] grant_data_s;
  logic               grant_valid_s;
  cdb_src_e           grant_src_s;
  logic               pop_alu_s;
  logic               pop_lsb_s;

  logic                cdb_valid_r;
  logic [ROB_ID_W-1:0] cdb_rob_id_r;
  logic [DATA_W-1:0]   cdb_value_r;
  cdb_src_e            cdb_src_r;

  assign act_s   = bus.rdy_in && !bus.clear_all;
  assign flush_s = bus.rdy_in && bus.clear_all;

  cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(QUEUE_DEPTH)) u_alu_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (bus.alu_valid && act_s),
    .pop       (pop_alu_s),
    .flush     (flush_s),
    .push_data ({bus.alu_rob_id, bus.alu_value}),
    .head_data (alu_head_s),
    .full      (alu_full_s),
    .empty     (alu_empty_s)
  );

  cdb_fifo #(.WIDTH(ENTRY_W), .DEPTH(QUEUE_DEPTH)) u_lsb_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (bus.lsb_valid && act_s),
    .pop       (pop_lsb_s),
    .flush     (flush_s),
    .push_data ({bus.lsb_rob_id, bus.lsb_value}),
    .head_data (lsb_head_s),
    .full      (lsb_full_s),
    .empty     (lsb_empty_s)
  );

`ifdef CDB_PRIO_LSB_EN
  // Fixed priority: the LSB always wins a conflict, so no grant history is kept.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = SRC_ALU;
    if (act_s && !lsb_empty_s) begin
      grant_valid_s = 1'b1;
      grant_src_s   = SRC_LSB;
    end else if (act_s && !alu_empty_s) begin
      grant_valid_s = 1'b1;
      grant_src_s   = SRC_ALU;
    end else begin
      grant_valid_s = 1'b0;
      grant_src_s   = SRC_ALU;
    end
  end
`else
  cdb_src_e last_grant_r;

  // Round-robin: a conflict goes to the source that lost the previous one.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = SRC_ALU;
    if (act_s && !alu_empty_s && !lsb_empty_s) begin
      grant_valid_s = 1'b1;
      grant_src_s   = rr_other(last_grant_r);
    end else if (act_s && !alu_empty_s) begin
      grant_valid_s = 1'b1;
      grant_src_s   = SRC_ALU;
    end else if (act_s && !lsb_empty_s) begin
      grant_valid_s = 1'b1;
      grant_src_s   = SRC_LSB;
    end else begin
      grant_valid_s = 1'b0;
      grant_src_s   = SRC_ALU;
    end
  end

  // Grant history; starts at LSB so the ALU wins the first conflict.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      last_grant_r <= SRC_LSB;
    end else if (flush_s) begin
      last_grant_r <= SRC_LSB;
    end else if (grant_valid_s) begin
      last_grant_r <= grant_src_s;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end
`endif

  // Head-entry select and pop strobes for the winning queue.
  always_comb begin
    pop_alu_s    = grant_valid_s && (grant_src_s == SRC_ALU);
    pop_lsb_s    = grant_valid_s && (grant_src_s == SRC_LSB);
    grant_data_s = (grant_src_s == SRC_LSB) ? lsb_head_s : alu_head_s;
  end

  // Broadcast registers; frozen while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cdb_valid_r  <= 1'b0;
      cdb_rob_id_r <= '0;
      cdb_value_r  <= '0;
      cdb_src_r    <= SRC_ALU;
    end else if (bus.rdy_in) begin
      if (bus.clear_all) begin
        cdb_valid_r <= 1'b0;
      end else if (grant_valid_s) begin
        cdb_valid_r  <= 1'b1;
        cdb_rob_id_r <= grant_data_s[ENTRY_W-1:DATA_W];
        cdb_value_r  <= grant_data_s[DATA_W-1:0];
        cdb_src_r    <= grant_src_s;
      end else begin
        cdb_valid_r <= 1'b0;
      end
    end
  end

  assign bus.alu_full   = alu_full_s;
  assign bus.lsb_full   = lsb_full_s;
  assign bus.cdb_valid  = cdb_valid_r;
  assign bus.cdb_rob_id = cdb_rob_id_r;
  assign bus.cdb_value  = cdb_value_r;
  assign bus.cdb_src    = cdb_src_r;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a behavioural queue model predicts every broadcast.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int RW = DEF_ROB_ID_W;
  localparam int QD = DEF_QUEUE_DEPTH;

  logic clk_in = 1'b0;
  logic rst_in;

  cdb_arbiter_if #(.ROB_ID_W(RW)) bus();

  cdb_arbiter #(.ROB_ID_W(RW), .QUEUE_DEPTH(QD)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  logic [RW+31:0] m_alu[$];
  logic [RW+31:0] m_lsb[$];
  logic [RW+32:0] sb[$];
  logic           m_valid, m_src, m_last, m_new;
  logic [RW-1:0]  m_rob;
  logic [31:0]    m_value;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_alu.delete();
    m_lsb.delete();
    sb.delete();
    m_valid = 1'b0;
    m_src   = 1'b0;
    m_rob   = '0;
    m_value = '0;
    m_last  = 1'b1;
    m_new   = 1'b0;
  endtask

  task automatic model_edge(input logic av, input logic [RW-1:0] ar, input logic [31:0] ad,
                            input logic lv, input logic [RW-1:0] lr, input logic [31:0] ld,
                            input logic rdy, input logic clr);
    logic af, lf, s;
    logic [RW+31:0] e;
    m_new = 1'b0;
    if (!rdy) return;
    if (clr) begin
      m_alu.delete();
      m_lsb.delete();
      m_valid = 1'b0;
      m_last  = 1'b1;
      return;
    end
    af = (m_alu.size() == QD);
    lf = (m_lsb.size() == QD);
    if (m_alu.size() != 0 && m_lsb.size() != 0) begin
`ifdef CDB_PRIO_LSB_EN
      s = 1'b1;
`else
      s = ~m_last;
`endif
    end else begin
      s = (m_lsb.size() != 0);
    end
    if (m_alu.size() != 0 || m_lsb.size() != 0) begin
      e       = s ? m_lsb.pop_front() : m_alu.pop_front();
      m_valid = 1'b1;
      m_rob   = e[RW+31:32];
      m_value = e[31:0];
      m_src   = s;
      m_last  = s;
      m_new   = 1'b1;
      sb.push_back({s, e});
    end else begin
      m_valid = 1'b0;
    end
    if (av && !af) m_alu.push_back({ar, ad});
    if (lv && !lf) m_lsb.push_back({lr, ld});
  endtask

  task automatic compare();
    logic [RW+32:0] x;
    check_eq("cdb_valid", 64'(bus.cdb_valid), 64'(m_valid));
    check_eq("alu_full", 64'(bus.alu_full), 64'(m_alu.size() == QD));
    check_eq("lsb_full", 64'(bus.lsb_full), 64'(m_lsb.size() == QD));
    if (m_new) begin
      if (sb.size() == 0) begin
        check_eq("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        x = sb.pop_front();
        check_eq("bcast_src", 64'(bus.cdb_src), 64'(x[RW+32]));
        check_eq("bcast_rob", 64'(bus.cdb_rob_id), 64'(x[RW+31:32]));
        check_eq("bcast_value", 64'(bus.cdb_value), 64'(x[31:0]));
      end
    end else begin
      check_eq("hold_src", 64'(bus.cdb_src), 64'(m_src));
      check_eq("hold_rob", 64'(bus.cdb_rob_id), 64'(m_rob));
      check_eq("hold_value", 64'(bus.cdb_value), 64'(m_value));
    end
  endtask

  // One clock: drive at the falling edge, model at the rising edge, compare 1 time unit later.
  task automatic cyc(input logic av, input logic [RW-1:0] ar, input logic [31:0] ad,
                     input logic lv, input logic [RW-1:0] lr, input logic [31:0] ld,
                     input logic rdy, input logic clr);
    bus.alu_valid  = av;
    bus.alu_rob_id = ar;
    bus.alu_value  = ad;
    bus.lsb_valid  = lv;
    bus.lsb_rob_id = lr;
    bus.lsb_value  = ld;
    bus.rdy_in     = rdy;
    bus.clear_all  = clr;
    @(posedge clk_in);
    model_edge(av, ar, ad, lv, lr, ld, rdy, clr);
    #1;
    compare();
    @(negedge clk_in);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 32'h0, 1'b0, '0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic apply_reset();
    bus.alu_valid = 1'b0;
    bus.lsb_valid = 1'b0;
    bus.clear_all = 1'b0;
    bus.rdy_in    = 1'b1;
    #2;
    rst_in = 1'b1;
    #1;
    model_reset();
    compare();
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in         = 1'b1;
    bus.rdy_in     = 1'b1;
    bus.clear_all  = 1'b0;
    bus.alu_valid  = 1'b0;
    bus.alu_rob_id = '0;
    bus.alu_value  = 32'h0;
    bus.lsb_valid  = 1'b0;
    bus.lsb_rob_id = '0;
    bus.lsb_value  = 32'h0;
    model_reset();
    repeat (2) @(negedge clk_in);
    #1;
    compare();
    rst_in = 1'b0;
    @(negedge clk_in);

    // Single ALU push, broadcast the following cycle, then a gap.
    cyc(1'b1, RW'(3), 32'h11, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    repeat (3) idle();

    // Simultaneous pushes straight after reset decide the first conflict.
    apply_reset();
    cyc(1'b1, RW'(1), 32'hA, 1'b1, RW'(2), 32'hB, 1'b1, 1'b0);
    repeat (3) idle();

    // Both sources push every cycle long enough to reach full and drop pushes.
    for (int i = 0; i < 12; i++)
      cyc(1'b1, RW'(i), 32'(32'h100 + i), 1'b1, RW'(i + 3), 32'(32'h200 + i), 1'b1, 1'b0);
    repeat (12) idle();

    // LSB tags 4..7, then a paused window where pushes and clear_all are ignored.
    for (int i = 0; i < 4; i++)
      cyc(1'b0, '0, 32'h0, 1'b1, RW'(4 + i), 32'(32'h300 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      cyc(1'b1, RW'(9), 32'hDEAD, 1'b1, RW'(10), 32'hBEEF, 1'b0, (i == 2) ? 1'b1 : 1'b0);
    repeat (4) idle();

    // Build a backlog in both queues, then flush it.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, RW'(i + 8), 32'(32'h400 + i), 1'b1, RW'(i), 32'(32'h500 + i), 1'b1, 1'b0);
    cyc(1'b1, RW'(13), 32'h405, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    cyc(1'b1, RW'(14), 32'h406, 1'b1, RW'(15), 32'h506, 1'b1, 1'b1);
    repeat (4) idle();

    // Asynchronous reset in the middle of a stream.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, RW'(i), 32'(32'h600 + i), 1'b1, RW'(i + 4), 32'(32'h700 + i), 1'b1, 1'b0);
    apply_reset();
    cyc(1'b1, RW'(9), 32'h99, 1'b0, '0, 32'h0, 1'b1, 1'b0);
    repeat (3) idle();

    // Random legal traffic with pauses and occasional flushes.
    for (int i = 0; i < 60; i++) begin
      logic av, lv, rdy, clr;
      av  = ($urandom_range(0, 3) != 0) && (m_alu.size() < QD);
      lv  = ($urandom_range(0, 3) != 0) && (m_lsb.size() < QD);
      rdy = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 19) == 0);
      cyc(av, RW'($urandom), $urandom, lv, RW'($urandom), $urandom, rdy, clr);
    end
    repeat (10) idle();

    check_eq("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
